// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit for the EX stage.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract) on
// operand magnitudes, then applies signs in a final fix-up cycle. Also holds
// the architectural HI/LO registers written by MTHI/MTLO.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start, op, a, b  new operation request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   mthi, mtlo       write wr_data into HI / LO while idle
//   cancel           abort an in-flight operation (exception flush)
//   busy             operation in flight
//   done             one-cycle pulse, hi/lo just took a new result
//   hi, lo           HI / LO registers
module mult_div_unit #(
    parameter int unsigned SIZE = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [SIZE:0]   a,
    input  logic [SIZE:0]   b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [SIZE:0]   wr_data,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [SIZE:0]   hi,
    output logic [SIZE:0]   lo
);

    localparam int unsigned W  = SIZE + 1;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [W-1:0]    b_mag_q, b_mag_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;      // negate product / quotient
    logic            rem_neg_q, rem_neg_d;
    logic            bz_q, bz_d;        // divisor was zero
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    // Operand magnitudes and sign bookkeeping at issue.
    logic            signed_c;
    logic [W-1:0]    a_mag_c, b_mag_c;

    always_comb begin
        signed_c = ~op[0];
        a_mag_c  = (signed_c && a[SIZE]) ? (W'(0) - a) : a;
        b_mag_c  = (signed_c && b[SIZE]) ? (W'(0) - b) : b;
    end

    // One multiply step: conditionally add multiplicand, shift right.
    logic [W:0]      mul_sum_c;
    logic [2*W-1:0]  mul_next_c;

    always_comb begin
        mul_sum_c  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? b_mag_q : W'(0))};
        mul_next_c = {mul_sum_c, acc_q[W-1:1]};
    end

    // One restoring divide step: shift in next dividend bit, trial subtract.
    // The remainder stays below the divisor, so the W-bit difference is exact.
    logic [W:0]      div_tmp_c;
    logic [W-1:0]    div_diff_c;
    logic            div_ge_c;
    logic [2*W-1:0]  div_next_c;

    always_comb begin
        div_tmp_c  = acc_q[2*W-1:W-1];
        div_ge_c   = (div_tmp_c >= {1'b0, b_mag_q});
        div_diff_c = div_tmp_c[W-1:0] - b_mag_q;
        div_next_c = {(div_ge_c ? div_diff_c : div_tmp_c[W-1:0]), acc_q[W-2:0], div_ge_c};
    end

    // Sign fix-up of the finished magnitude result.
    logic [2*W-1:0]  prod_c;
    logic [W-1:0]    quo_c, rem_c;

    always_comb begin
        prod_c = neg_q ? ((2*W)'(0) - acc_q) : acc_q;
        // A zero divisor leaves quotient all ones regardless of operand signs.
        quo_c  = (neg_q && !bz_q) ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
        rem_c  = rem_neg_q ? (W'(0) - acc_q[2*W-1:W]) : acc_q[2*W-1:W];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_mag_d   = b_mag_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        bz_d      = bz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!cancel) begin
                        state_d   = S_RUN;
                        cnt_d     = CW'(SIZE);
                        acc_d     = {W'(0), a_mag_c};
                        b_mag_d   = b_mag_c;
                        is_div_d  = op[1];
                        neg_d     = signed_c & (a[SIZE] ^ b[SIZE]);
                        rem_neg_d = signed_c & op[1] & a[SIZE];
                        bz_d      = (b == W'(0));
                    end
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next_c : mul_next_c;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(0)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_c;
                        lo_d = quo_c;
                    end else begin
                        hi_d = prod_c[2*W-1:W];
                        lo_d = prod_c[W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_mag_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_mag_q   <= b_mag_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            bz_q      <= bz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;

    localparam int unsigned SIZE = 31;
    localparam int          LIM  = 60;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        mthi, mtlo;
    logic [31:0] wr_data;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];

    int   lat, bcnt;
    bit   got;

    mult_div_unit #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue an operation in the current cycle and record its expected result.
    task automatic start_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        op = o; a = av; b = bv; start = 1'b1;
        e.hi = eh; e.lo = el;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Run cycles until done (bounded), optionally injecting ignored requests,
    // cancel or reset at a given cycle offset after the start edge.
    task automatic wait_done(input int inj, input int cc, input int rc,
                             output int l, output int bc, output bit g);
        int cyc = 0;
        bc = 0; g = 1'b0;
        while (cyc < LIM && !g) begin
            if (done) begin
                g = 1'b1;
            end else begin
                if (busy) bc++;
                start  = (cyc == inj);
                mthi   = (cyc == inj);
                op     = 2'b11; a = 32'd9; b = 32'd3; wr_data = 32'hAA;
                cancel = (cyc == cc);
                reset  = (cyc == rc);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0; mthi = 1'b0; cancel = 1'b0; reset = 1'b0;
        l = cyc;
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        end
    endtask

    // Full operation: start, wait, check latency/busy span/result.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
        start_op(o, av, bv, eh, el);
        wait_done(-1, -1, -1, lat, bcnt, got);
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(SIZE + 2));
        pop_chk(tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic arithmetic, signed and unsigned.
        do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        chk("multu_max_busy", 64'(bcnt), 64'd33);
        do_op("mult_neg", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        do_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        do_op("divu_zero", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
        do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        do_op("div_negzero", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // Start and mthi while busy are ignored; back-to-back start on done cycle.
        start_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30);
        wait_done(10, -1, -1, lat, bcnt, got);
        chk("ign_done", 64'(got), 64'd1);
        chk("ign_lat", 64'(lat), 64'(SIZE + 2));
        chk("ign_busy", 64'(bcnt), 64'd33);
        pop_chk("ign");
        start_op(2'b01, 32'd7, 32'd8, 32'd0, 32'd56);
        wait_done(-1, -1, -1, lat, bcnt, got);
        chk("b2b_done", 64'(got), 64'd1);
        chk("b2b_lat", 64'(lat), 64'(SIZE + 2));
        pop_chk("b2b");
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);

        // Simultaneous mthi/mtlo while idle.
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_hi", 64'(hi), 64'hDEADBEEF);
        chk("mt_lo", 64'(lo), 64'hDEADBEEF);
        chk("mt_done", 64'(done), 64'd0);

        // Cancel mid-run: no done, hi/lo untouched.
        op = 2'b00; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(-1, 15, -1, lat, bcnt, got);
        chk("cancel_nodone", 64'(got), 64'd0);
        chk("cancel_busy", 64'(bcnt), 64'd16);
        chk("cancel_hi", 64'(hi), 64'hDEADBEEF);
        chk("cancel_lo", 64'(lo), 64'hDEADBEEF);

        // Reset mid-run: everything cleared.
        op = 2'b00; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(-1, -1, 15, lat, bcnt, got);
        chk("rstrun_nodone", 64'(got), 64'd0);
        chk("rstrun_busyspan", 64'(bcnt), 64'd16);
        chk("rstrun_hi", 64'(hi), 64'd0);
        chk("rstrun_lo", 64'(lo), 64'd0);
        chk("rstrun_busy", 64'(busy), 64'd0);

        // Recovery after reset.
        do_op("after_rst", 2'b00, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd0, 32'd49);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
